// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: op codes, FSM state
// encoding and the EXEC cycle count helper.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_XOR  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_BSUB = 3'b110;
  localparam logic [2:0] ALU_SRA  = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Remaining EXEC cycles after the first; only mul takes more than one.
  function automatic logic [3:0] exec_cnt_init(input logic [2:0] ctr,
                                               input logic [3:0] mul_lat);
    return (ctr == ALU_MUL) ? mul_lat - 4'd1 : 4'd0;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin grant: with both requests pending the pointer holder
// wins, otherwise the single requester wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters: IDLE -> EXEC -> RESP.
// Optional performance counters are built when ALU_SHARE_PERF_EN is defined.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [5:0]          req_ctr_i,
  input  logic [2*DATA_W-1:0] req_rs1_i,
  input  logic [2*DATA_W-1:0] req_rs2_i,
  output logic [1:0]          rsp_valid_o,
  input  logic [1:0]          rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_data_o,
  output logic [2:0]          alu_ctr_o,
  output logic [DATA_W-1:0]   alu_rs1_o,
  output logic [DATA_W-1:0]   alu_rs2_o,
  input  logic [DATA_W-1:0]   alu_rd_i,
  output logic                busy_o
`ifdef ALU_SHARE_PERF_EN
  ,
  output logic [31:0]         perf_ops0_o,
  output logic [31:0]         perf_ops1_o,
  output logic [31:0]         perf_conflict_o
`endif
);

  localparam logic [3:0] MUL_LAT_W = 4'(MUL_LAT);

  logic [1:0]        state_reg;
  logic              ptr_reg;
  logic              id_reg;
  logic [3:0]        cnt_reg;
  logic [2:0]        ctr_reg;
  logic [DATA_W-1:0] rs1_reg;
  logic [DATA_W-1:0] rs2_reg;
  logic [DATA_W-1:0] rd_reg;

  logic [1:0]        grant;
  logic              grant_id;
  logic              accept;
  logic              rsp_done;
  logic [2:0]        sel_ctr;

  rr_arb2 u_arb (
    .valid (req_valid_i),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  assign grant_id = grant[1];
  assign accept   = (state_reg == ST_IDLE) && (grant != 2'b00);
  assign rsp_done = (state_reg == ST_RESP) && rsp_ready_i[id_reg];
  assign sel_ctr  = grant_id ? req_ctr_i[5:3] : req_ctr_i[2:0];

  // Ready is gated by reset so it reads zero while reset is held.
  assign req_ready_o = (state_reg == ST_IDLE && !rst_i) ? grant : 2'b00;
  assign rsp_valid_o = (state_reg == ST_RESP) ? (id_reg ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data_o  = rd_reg;
  assign alu_ctr_o   = ctr_reg;
  assign alu_rs1_o   = rs1_reg;
  assign alu_rs2_o   = rs2_reg;
  assign busy_o      = (state_reg != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= 1'b0;
      id_reg    <= 1'b0;
      cnt_reg   <= 4'd0;
      ctr_reg   <= 3'd0;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      rd_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            id_reg    <= grant_id;
            ctr_reg   <= sel_ctr;
            rs1_reg   <= req_rs1_i[grant_id*DATA_W +: DATA_W];
            rs2_reg   <= req_rs2_i[grant_id*DATA_W +: DATA_W];
            cnt_reg   <= exec_cnt_init(sel_ctr, MUL_LAT_W);
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_reg == 4'd0) begin
            rd_reg    <= alu_rd_i;
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_done) begin
            ptr_reg   <= ~id_reg;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SHARE_PERF_EN
  logic [31:0] ops0_reg;
  logic [31:0] ops1_reg;
  logic [31:0] conflict_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ops0_reg     <= 32'd0;
      ops1_reg     <= 32'd0;
      conflict_reg <= 32'd0;
    end else begin
      if (rsp_done && !id_reg) ops0_reg <= ops0_reg + 32'd1;
      if (rsp_done && id_reg)  ops1_reg <= ops1_reg + 32'd1;
      if (state_reg == ST_IDLE && req_valid_i == 2'b11) begin
        conflict_reg <= conflict_reg + 32'd1;
      end
    end
  end

  assign perf_ops0_o     = ops0_reg;
  assign perf_ops1_o     = ops1_reg;
  assign perf_conflict_o = conflict_reg;
`endif

endmodule
